// File: rtl/piso_shift.sv
// piso_shift: parallel-in serial-out transmitter.
// Takes a WIDTH-bit word over a valid/ready handshake and emits it one bit per
// clock on q, framed by q_valid/q_last. A new word may be accepted during the
// last bit of the current one, so back-to-back words stream without a gap.
module piso_shift #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] din,
    output logic             load_ready,
    output logic             q,
    output logic             q_valid,
    output logic             q_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic             at_last;
    logic             accept;
    logic             out_bit;

    // Handshake and framing decode, all derived from the current registers.
    always_comb begin
        at_last    = (cnt == LAST_CNT);
        busy       = (state == SHIFT);
        load_ready = (state == IDLE) || (busy && at_last);
        accept     = load_valid && load_ready;
        out_bit    = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        q          = busy && out_bit;
        q_valid    = busy;
        q_last     = busy && at_last;
    end

    // Next-state logic: load, shift toward the output end with zero fill, or reload on the last bit.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shreg_next = shreg;
        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_next = din;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (!at_last) begin
                    shreg_next = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                    cnt_next   = cnt + 1'b1;
                end else if (accept) begin
                    shreg_next = din;
                    cnt_next   = '0;
                end else begin
                    shreg_next = '0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                shreg_next = '0;
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // State, counter and shift register; reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            shreg <= shreg_next;
        end
    end

endmodule

// File: tb/tb_piso_shift.sv
// tb_piso_shift: directed table-driven bench for piso_shift (WIDTH=4), with
// an MSB-first instance for the main vectors and an LSB-first instance whose
// serial output feeds a 4-bit serial-in register.
module tb_piso_shift;

    typedef struct {
        logic       rst;
        logic       lv;
        logic [3:0] din;
        logic [4:0] exp;   // {q, q_valid, q_last, busy, load_ready}
    } vector_t;

    logic       clk;
    logic       rst;
    logic       load_valid;
    logic [3:0] din;
    logic       load_ready, q, q_valid, q_last, busy;

    logic       lsb_load_valid;
    logic [3:0] lsb_din;
    logic       lsb_load_ready, lsb_q, lsb_q_valid, lsb_q_last, lsb_busy;
    logic [3:0] sipo_q;

    int checks;
    int failures;

    vector_t vecs[$];

    piso_shift #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .din       (din),
        .load_ready(load_ready),
        .q         (q),
        .q_valid   (q_valid),
        .q_last    (q_last),
        .busy      (busy)
    );

    piso_shift #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .load_valid(lsb_load_valid),
        .din       (lsb_din),
        .load_ready(lsb_load_ready),
        .q         (lsb_q),
        .q_valid   (lsb_q_valid),
        .q_last    (lsb_q_last),
        .busy      (lsb_busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream 4-bit serial-in register fed by the LSB-first serial output.
    always_ff @(posedge clk) begin
        sipo_q <= {sipo_q[2:0], lsb_q};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic lv, input logic [3:0] d);
        rst        = r;
        load_valid = lv;
        din        = d;
    endtask

    initial begin
        logic [3:0] exp_bits;
        logic [3:0] model;
        int         nbits;
        int         budget;

        checks         = 0;
        failures       = 0;
        sipo_q         = 4'b0000;
        lsb_load_valid = 1'b0;
        lsb_din        = 4'b0000;
        applyStimulus(1'b1, 1'b0, 4'b0000);

        // Reset held for two cycles, then idle.
        vecs.push_back('{1'b1, 1'b0, 4'b0000, 5'b00001});
        vecs.push_back('{1'b1, 1'b0, 4'b0000, 5'b00001});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 5'b00001});
        // Single word 1011.
        vecs.push_back('{1'b0, 1'b1, 4'b1011, 5'b11010});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 5'b01010});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 5'b11010});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 5'b11111});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 5'b00001});
        // Back-to-back 1011 then 0110 presented at q_last.
        vecs.push_back('{1'b0, 1'b1, 4'b1011, 5'b11010});
        vecs.push_back('{1'b0, 1'b1, 4'b1011, 5'b01010});
        vecs.push_back('{1'b0, 1'b1, 4'b0110, 5'b11010});
        vecs.push_back('{1'b0, 1'b1, 4'b0110, 5'b11111});
        vecs.push_back('{1'b0, 1'b1, 4'b0110, 5'b01010});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 5'b11010});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 5'b11010});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 5'b01111});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 5'b00001});
        // Load attempt while busy: 1001 in flight, 1111 waits for q_last.
        vecs.push_back('{1'b0, 1'b1, 4'b1001, 5'b11010});
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 5'b01010});
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 5'b01010});
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 5'b11111});
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 5'b11010});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 5'b11010});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 5'b11010});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 5'b11111});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 5'b00001});
        // Reset after two bits of 1100, reset beats a pending load, then 0011.
        vecs.push_back('{1'b0, 1'b1, 4'b1100, 5'b11010});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 5'b11010});
        vecs.push_back('{1'b1, 1'b1, 4'b0011, 5'b00001});
        vecs.push_back('{1'b0, 1'b1, 4'b0011, 5'b01010});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 5'b01010});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 5'b11010});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 5'b11111});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 5'b00001});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].lv, vecs[i].din);
            tick();
            checkOutput($sformatf("row%0d q", i),          {3'b000, q},          {3'b000, vecs[i].exp[4]});
            checkOutput($sformatf("row%0d q_valid", i),    {3'b000, q_valid},    {3'b000, vecs[i].exp[3]});
            checkOutput($sformatf("row%0d q_last", i),     {3'b000, q_last},     {3'b000, vecs[i].exp[2]});
            checkOutput($sformatf("row%0d busy", i),       {3'b000, busy},       {3'b000, vecs[i].exp[1]});
            checkOutput($sformatf("row%0d load_ready", i), {3'b000, load_ready}, {3'b000, vecs[i].exp[0]});
        end

        // LSB-first word 1011 streamed into the serial-in register.
        applyStimulus(1'b0, 1'b0, 4'b0000);
        lsb_load_valid = 1'b1;
        lsb_din        = 4'b1011;
        tick();
        lsb_load_valid = 1'b0;
        lsb_din        = 4'b0000;
        exp_bits = 4'b1101;   // bits in transmit order: 1,1,0,1
        model    = 4'b0000;
        nbits    = 0;
        budget   = 0;
        while (nbits < 4 && budget < 12) begin
            if (lsb_q_valid) begin
                checkOutput($sformatf("lsb bit%0d", nbits), {3'b000, lsb_q}, {3'b000, exp_bits[3 - nbits]});
                checkOutput($sformatf("lsb q_last bit%0d", nbits), {3'b000, lsb_q_last},
                            {3'b000, (nbits == 3) ? 1'b1 : 1'b0});
                model = {model[2:0], lsb_q};
                nbits++;
            end
            tick();
            budget++;
        end
        checkOutput("lsb bits received", nbits[3:0], 4'd4);
        checkOutput("lsb idle after word", {3'b000, lsb_q_valid}, 4'b0000);
        checkOutput("sipo vs model", sipo_q, model);
        checkOutput("sipo word", sipo_q, 4'b1101);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
